// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier with a start/done handshake and run-time signed/unsigned mode.
// Optional feature MULT_ZERO_SKIP_EN: a zero operand at start goes directly to DONE with product 0.
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // state | meaning
    // IDLE  | waiting for start; product held
    // CALC  | one Booth step per cycle, WIDTH+1 steps
    // DONE  | one-cycle done pulse; start ignored
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 2);

    state_t              state_q, state_d;
    logic [WIDTH:0]      a_q, a_d, q_q, q_d, m_q, m_d;
    logic                q1_q, q1_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]      x_ext, y_ext, sum, a_sh, q_sh;

    // Extending both operands by one bit lets one signed Booth datapath serve both modes.
    assign x_ext = {is_signed & x[WIDTH-1], x};
    assign y_ext = {is_signed & y[WIDTH-1], y};

    always_comb begin
        sum = a_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
    end

    assign a_sh = {sum[WIDTH], sum[WIDTH:1]};
    assign q_sh = {sum[0], q_q[WIDTH:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MULT_ZERO_SKIP_EN
                    if ((x == '0) || (y == '0)) begin
                        state_d = DONE;
                        prod_d  = '0;
                    end else begin
                        state_d = CALC;
                        a_d     = '0;
                        q_d     = y_ext;
                        q1_d    = 1'b0;
                        m_d     = x_ext;
                        cnt_d   = CW'(WIDTH + 1);
                    end
`else
                    state_d = CALC;
                    a_d     = '0;
                    q_d     = y_ext;
                    q1_d    = 1'b0;
                    m_d     = x_ext;
                    cnt_d   = CW'(WIDTH + 1);
`endif
                end
            end
            CALC: begin
                a_d   = a_sh;
                q_d   = q_sh;
                q1_d  = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    prod_d  = {a_sh[WIDTH-2:0], q_sh};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for seq_booth_multiplier at WIDTH=32 (expected products queued at start, checked at done).
module tb_seq_booth_multiplier;

    localparam int W = 32;
`ifdef MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT  = 0;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = W + 1;
    localparam int ZERO_BUSY = W + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            is_signed = 1'b0;
    logic [W-1:0]    x = '0;
    logic [W-1:0]    y = '0;
    logic            busy, done;
    logic [2*W-1:0]  product;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [2*W-1:0] sb_q[$];

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .x(x), .y(y), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic signed [2*W-1:0] sa, sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Returns at the negedge following the start-sampling edge, with operands scrambled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
        @(negedge clk);
        x = a; y = b; is_signed = s; start = 1'b1;
        if (push) sb_q.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
        x = $urandom; y = $urandom; is_signed = $urandom_range(0, 1);
    endtask

    // lat = number of edges after the start edge at which done rose; -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cyc);
        bit seen = 0;
        lat = -1;
        busy_cyc = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (done) begin
                lat = n;
                seen = 1;
            end else begin
                if (busy) busy_cyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = $urandom_range(0, 1); x = $urandom; y = $urandom; is_signed = $urandom_range(0, 1);
        end
        n_cmp++;
        if ({busy, done, product} !== {2'b00, {2*W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b product=%h required 0 0 0", busy, done, product);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = $urandom; y = $urandom;
        end
        n_cmp++;
        if ({busy, done, product} !== {2'b00, {2*W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_release_hold: busy=%b done=%b product=%h required 0 0 0", busy, done, product);
        end
    endtask

    task automatic test_signed_small();
        int lat, bc;
        logic [2*W-1:0] exp_p;
        issue(-32'sd7, 32'sd6, 1'b1, 1);
        wait_done(lat, bc);
        exp_p = sb_q.pop_front();
        n_cmp++;
        if (lat !== W + 1) begin n_fail++; $display("FAIL signed_latency: got %0d required %0d", lat, W + 1); end
        n_cmp++;
        if (bc !== W + 1) begin n_fail++; $display("FAIL signed_busy_cycles: got %0d required %0d", bc, W + 1); end
        n_cmp++;
        if (product !== exp_p || product !== 64'hFFFF_FFFF_FFFF_FFD6) begin
            n_fail++; $display("FAIL signed_product: got %h required %h", product, 64'hFFFF_FFFF_FFFF_FFD6);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: done=%b required 0", done); end
    endtask

    task automatic test_mode_and_corners();
        logic [W-1:0] av[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] bv[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};
        logic         sv[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2*W-1:0] cv[5] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                                  64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
                                  64'h0000_0001_0000_0000};
        int lat, bc;
        logic [2*W-1:0] exp_p;
        for (int i = 0; i < 5; i++) begin
            issue(av[i], bv[i], sv[i], 1);
            wait_done(lat, bc);
            exp_p = sb_q.pop_front();
            n_cmp++;
            if (lat !== W + 1 || product !== exp_p || product !== cv[i]) begin
                n_fail++;
                $display("FAIL corner_%0d: lat=%0d product=%h required lat=%0d product=%h", i, lat, product, W + 1, cv[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int lat, bc, extra;
        logic [2*W-1:0] exp_p;
        issue(32'd3, 32'd5, 1'b0, 1);
        for (int i = 1; i < 10; i++) @(negedge clk);
        x = 32'd9; y = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        exp_p = sb_q.pop_front();
        n_cmp++;
        if (lat !== W + 1 - 10 || product !== exp_p || product !== 64'd15) begin
            n_fail++; $display("FAIL busy_restart_ignored: lat=%0d product=%h required lat=%0d product=15", lat, product, W + 1 - 10);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_cmp++;
        if (extra !== 0 || product !== 64'd15) begin
            n_fail++; $display("FAIL single_done_hold: extra_dones=%0d product=%h required 0 and 15", extra, product);
        end
        issue(32'd2, 32'd2, 1'b0, 1);
        for (int i = 0; i < 15; i++) @(negedge clk);
        n_cmp++;
        if (product !== 64'd15 || busy !== 1'b1) begin
            n_fail++; $display("FAIL hold_during_next: product=%h busy=%b required 15 1", product, busy);
        end
        wait_done(lat, bc);
        exp_p = sb_q.pop_front();
        n_cmp++;
        if (product !== exp_p) begin n_fail++; $display("FAIL next_product: got %h required %h", product, exp_p); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [W-1:0] a, b;
        logic s;
        logic [2*W-1:0] exp_p;
        issue($urandom, $urandom, 1'b1, 1);
        wait_done(lat, bc);
        for (int i = 0; i < 4; i++) begin
            exp_p = sb_q.pop_front();
            n_cmp++;
            if (lat !== W + 1 || product !== exp_p) begin
                n_fail++; $display("FAIL b2b_%0d: lat=%0d product=%h required lat=%0d product=%h", i, lat, product, W + 1, exp_p);
            end
            if (i == 3) break;
            // start raised during DONE: ignored at k+W+2, accepted at k+W+3
            a = $urandom; b = $urandom; s = $urandom_range(0, 1);
            x = a; y = b; is_signed = s; start = 1'b1;
            sb_q.push_back(model(a, b, s));
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL start_in_done_ignored: busy=%b done=%b required 0 0", busy, done);
            end
            @(negedge clk);
            start = 1'b0;
            wait_done(lat, bc);
        end
    endtask

    task automatic test_abort_and_zero();
        int lat, bc, dones;
        logic [2*W-1:0] exp_p;
        issue(32'd100, 32'd200, 1'b0, 0);
        for (int i = 1; i < 20; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, product} !== {2'b00, {2*W{1'b0}}}) begin
            n_fail++; $display("FAIL abort_reset: busy=%b done=%b product=%h required 0 0 0", busy, done, product);
        end
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_cmp++;
        if (dones !== 0 || product !== '0) begin
            n_fail++; $display("FAIL abort_no_done: activity=%0d product=%h required 0 0", dones, product);
        end
        issue(32'd0, 32'd123, 1'b0, 1);
        wait_done(lat, bc);
        exp_p = sb_q.pop_front();
        n_cmp++;
        if (lat !== ZERO_LAT || bc !== ZERO_BUSY || product !== exp_p) begin
            n_fail++; $display("FAIL zero_operand: lat=%0d busy=%0d product=%h required lat=%0d busy=%0d product=%h",
                               lat, bc, product, ZERO_LAT, ZERO_BUSY, exp_p);
        end
    endtask

    initial begin
        test_reset();
        test_signed_small();
        test_mode_and_corners();
        test_handshake();
        test_back_to_back();
        test_abort_and_zero();
        n_cmp++;
        if (sb_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d left required 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
